nios2_oci_trace_monitor: RTL and testbench

Synthesizable, parametrised successor to the OCI debug-trace test-bench sink. It captures debug trace words from the Nios II OCI into a circular buffer and presents them on a valid/ready read port. It sequences end-of-test by draining the buffer before flagging completion. It sits between the OCI trace packer and a JTAG/Avalon readout agent.

---
 rtl/nios2_oci_trace_pkg.sv | 36 +++
 rtl/nios2_oci_trace_fifo.sv | 82 ++++++++
 rtl/nios2_oci_trace_monitor.sv | 137 +++++++++++++
 tb/tb_nios2_oci_trace_monitor.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_pkg.sv
// -----------------------------------------------------------------------------
// nios2_oci_trace_pkg
// Shared definitions for the OCI trace monitor: FSM state encoding, timestamp
// width and width helpers used for port sizing.
// Optional feature macro: NIOS2_OCI_TRACE_MON_TIMESTAMP_EN (adds TS_W bits to
// every buffer entry).
// -----------------------------------------------------------------------------
package nios2_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_ENDED   = 2'd3
    } state_e;

    localparam int TS_W = 16;

    // Ceiling log2; used in constant expressions for port and pointer widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Width of one buffer entry: {dct_count, dct_buffer[, ts]}.
    function automatic int entry_w(input int cnt_w, input int dct_w);
`ifdef NIOS2_OCI_TRACE_MON_TIMESTAMP_EN
        return cnt_w + dct_w + TS_W;
`else
        return cnt_w + dct_w;
`endif
    endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// -----------------------------------------------------------------------------
// nios2_oci_trace_fifo
// Show-ahead circular buffer. The head entry is visible on rd_data_o in the
// same cycle it becomes valid; rd_data_o reads as zero while empty.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         empties the buffer (overrides push/pop)
//   push_i, pop_i   write at tail / advance head
//   wr_data_i       entry to write
//   rd_data_o       head entry
//   fill_level_o    occupied entries (one bit wider than the pointers)
//   full_o          fill_level_o == DEPTH
// -----------------------------------------------------------------------------
module nios2_oci_trace_fifo
    import nios2_oci_trace_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic [clog2(DEPTH):0]  fill_level_o,
    output logic                   full_o
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              empty, push_ok, pop_ok;

    assign empty        = (fill_q == '0);
    assign full_o       = (fill_q == FULL_LVL);
    assign pop_ok       = pop_i && !empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign push_ok      = push_i && (!full_o || pop_ok);
    assign fill_level_o = fill_q;
    assign rd_data_o    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_ok && !pop_ok)      fill_d = fill_q + FILL_ONE;
            else if (pop_ok && !push_ok) fill_d = fill_q - FILL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage is not reset; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/nios2_oci_trace_monitor.sv
// -----------------------------------------------------------------------------
// nios2_oci_trace_monitor
// Captures OCI debug trace words into a circular buffer, presents them on a
// valid/ready read port and sequences end-of-test by draining the buffer.
// Optional feature macro: NIOS2_OCI_TRACE_MON_TIMESTAMP_EN -- a free-running
// TS_W cycle counter is stored in the low bits of each entry.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   capture_en, clear       arm capture from IDLE / flush and return to IDLE
//   dct_valid, dct_buffer,
//   dct_count               trace word strobe, payload, slot count (0 = empty)
//   test_ending             request end-of-test drain
//   rd_valid, rd_ready,
//   rd_data                 show-ahead read port
//   fill_level              occupied entries
//   overflow, drop_count    sticky drop flag, saturating drop counter
//   test_has_ended, state_o ENDED indication, current state for debug
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | buffer empty, waiting for capture_en
// CAPTURE  | accepting trace words; reads allowed
// DRAIN    | no new words; waiting for the reader to empty the buffer
// ENDED    | buffer drained; test_has_ended high until clear
// -----------------------------------------------------------------------------
module nios2_oci_trace_monitor
    import nios2_oci_trace_pkg::*;
#(
    parameter int DCT_W  = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              capture_en,
    input  logic                              clear,
    input  logic                              dct_valid,
    input  logic [DCT_W-1:0]                  dct_buffer,
    input  logic [CNT_W-1:0]                  dct_count,
    input  logic                              test_ending,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [entry_w(CNT_W, DCT_W)-1:0]  rd_data,
    output logic [clog2(DEPTH):0]             fill_level,
    output logic                              overflow,
    output logic [DROP_W-1:0]                 drop_count,
    output logic                              test_has_ended,
    output logic [1:0]                        state_o
);
    localparam int ENTRY_W = entry_w(CNT_W, DCT_W);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    state_e              state_q, state_d;
    logic                ovf_q, ovf_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                qual_push, pop, full, drop;
    logic [ENTRY_W-1:0]  wr_entry;

    assign qual_push = (state_q == ST_CAPTURE) && dct_valid && (dct_count != '0);
    assign pop       = rd_valid && rd_ready;
    assign drop      = qual_push && full && !pop;

`ifdef NIOS2_OCI_TRACE_MON_TIMESTAMP_EN
    localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   ts_q <= '0;
        else if (clear) ts_q <= '0;
        else            ts_q <= ts_q + TS_ONE;
    end

    assign wr_entry = {dct_count, dct_buffer, ts_q};
`else
    assign wr_entry = {dct_count, dct_buffer};
`endif

    nios2_oci_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (reset_n),
        .flush_i      (clear),
        .push_i       (qual_push),
        .pop_i        (pop),
        .wr_data_i    (wr_entry),
        .rd_data_o    (rd_data),
        .fill_level_o (fill_level),
        .full_o       (full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (capture_en)         state_d = ST_CAPTURE;
            ST_CAPTURE: if (test_ending)        state_d = ST_DRAIN;
            // Sees the post-pop level, so ENDED follows the emptying pop by one edge.
            ST_DRAIN:   if (fill_level == '0)   state_d = ST_ENDED;
            ST_ENDED:   state_d = ST_ENDED;
            default:    state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clear) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign rd_valid       = (fill_level != '0);
    assign overflow       = ovf_q;
    assign drop_count     = drop_q;
    assign test_has_ended = (state_q == ST_ENDED);
    assign state_o        = state_q;

endmodule

// File: tb/tb_nios2_oci_trace_monitor.sv
module tb_nios2_oci_trace_monitor;
    localparam int DCT_W  = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;
`ifdef NIOS2_OCI_TRACE_MON_TIMESTAMP_EN
    localparam int TSB = 16;
`else
    localparam int TSB = 0;
`endif
    localparam int EW = CNT_W + DCT_W + TSB;
    localparam int PW = CNT_W + DCT_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              capture_en = 1'b0;
    logic              clear = 1'b0;
    logic              dct_valid = 1'b0;
    logic [DCT_W-1:0]  dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;
    logic              test_ending = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [EW-1:0]     rd_data;
    logic [4:0]        fill_level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic              test_has_ended;
    logic [1:0]        state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: a plain queue of entries plus the spec-level state number.
    logic [EW-1:0]     m_q[$];
    logic [1:0]        m_state;
    logic              m_ovf;
    logic [DROP_W-1:0] m_drop;
    logic [15:0]       m_ts;

    always #5 clk = ~clk;

    nios2_oci_trace_monitor #(
        .DCT_W (DCT_W), .CNT_W (CNT_W), .DEPTH (DEPTH), .DROP_W (DROP_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .capture_en     (capture_en),
        .clear          (clear),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .test_has_ended (test_has_ended),
        .state_o        (state_o)
    );

    task automatic model_reset();
        m_q.delete();
        m_state = 2'd0;
        m_ovf   = 1'b0;
        m_drop  = '0;
        m_ts    = '0;
    endtask

    // Advance one clock edge and apply the specification's rules to the model.
    task automatic tick();
        logic pop, qpush, clr;
        logic [EW-1:0] e;
        logic [1:0] ns;
        int sz;
        sz    = m_q.size();
        clr   = clear;
        pop   = (sz != 0) && rd_ready;
        qpush = (m_state == 2'd1) && dct_valid && (dct_count != '0);
`ifdef NIOS2_OCI_TRACE_MON_TIMESTAMP_EN
        e = {dct_count, dct_buffer, m_ts};
`else
        e = {dct_count, dct_buffer};
`endif
        ns = m_state;
        if (m_state == 2'd0 && capture_en)       ns = 2'd1;
        else if (m_state == 2'd1 && test_ending) ns = 2'd2;
        else if (m_state == 2'd2 && sz == 0)     ns = 2'd3;
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            model_reset();
        end else begin
            m_ts    = m_ts + 16'd1;
            m_state = ns;
            if (pop) void'(m_q.pop_front());
            if (qpush) begin
                if (sz < DEPTH || pop) m_q.push_back(e);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != '1) m_drop = m_drop + 1'b1;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        capture_en = 1'b0; clear = 1'b0; dct_valid = 1'b0; test_ending = 1'b0;
        rd_ready = 1'b0; dct_buffer = '0; dct_count = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #12;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (overflow !== 1'b0 || drop_count !== '0 || test_has_ended !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%b drop=%0d ended=%b exp 0/0/0", overflow, drop_count, test_has_ended);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [PW-1:0] exp_w [3];
        exp_w[0] = {4'd4, 30'h01234567};
        exp_w[1] = {4'd2, 30'h00ABCDEF};
        exp_w[2] = {4'd15, 30'h3FFFFFFF};
        capture_en = 1'b1;
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL basic_capture_state got %0d exp 1", state_o); end
        for (int i = 0; i < 3; i++) begin
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = exp_w[i];
            tick();
        end
        dct_valid = 1'b0;
        checks++; if (fill_level !== 5'd3) begin errors++; $display("FAIL basic_fill got %0d exp 3", fill_level); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data[EW-1:TSB] !== exp_w[i]) begin
                errors++; $display("FAIL basic_pop%0d got v=%b %h exp v=1 %h", i, rd_valid, rd_data[EW-1:TSB], exp_w[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty rd_valid got %b exp 0", rd_valid); end
    endtask

    task automatic test_overflow();
        logic [PW-1:0] words [20];
        rd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            words[i] = {4'($urandom_range(1, 15)), 30'($urandom)};
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = words[i];
            tick();
        end
        dct_valid = 1'b0;
        checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL ovf_fill got %0d exp 16", fill_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drop_count got %0d exp 4", drop_count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_data[EW-1:TSB] !== words[i]) begin
                errors++; $display("FAIL ovf_readback%0d got %h exp %h", i, rd_data[EW-1:TSB], words[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", fill_level); end
    endtask

    task automatic test_full_pushpop();
        logic [EW-1:0] exp_head;
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = {4'($urandom_range(1, 15)), 30'($urandom)};
            tick();
        end
        checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL fpp_fill got %0d exp 16", fill_level); end
        rd_ready = 1'b1;
        for (int i = 0; i < 40 + DEPTH; i++) begin
            dct_valid = (i < 40);
            {dct_count, dct_buffer} = {4'($urandom_range(1, 15)), 30'($urandom)};
            exp_head = m_q[0];
            checks++; if (rd_data !== exp_head) begin errors++; $display("FAIL fpp_head%0d got %h exp %h", i, rd_data, exp_head); end
            tick();
            if (i < 40) begin
                checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL fpp_level%0d got %0d exp 16", i, fill_level); end
            end
        end
        dct_valid = 1'b0;
        rd_ready  = 1'b0;
        checks++; if (fill_level !== 5'd0 || drop_count !== m_drop) begin
            errors++; $display("FAIL fpp_end got fill=%0d drop=%0d exp 0/%0d", fill_level, drop_count, m_drop);
        end
    endtask

    task automatic test_ignored();
        rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = {4'($urandom_range(1, 15)), 30'($urandom)};
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            dct_valid = 1'b1; dct_count = '0; dct_buffer = 30'($urandom);
            tick();
            checks++; if (fill_level !== 5'd2 || drop_count !== m_drop) begin
                errors++; $display("FAIL ign_zero_count got fill=%0d drop=%0d exp 2/%0d", fill_level, drop_count, m_drop);
            end
        end
        dct_valid = 1'b0; test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL ign_to_drain got %0d exp 2", state_o); end
        for (int i = 0; i < 5; i++) begin
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = {4'($urandom_range(1, 15)), 30'($urandom)};
            tick();
            checks++; if (fill_level !== 5'd2) begin errors++; $display("FAIL ign_drain_push got %0d exp 2", fill_level); end
        end
        dct_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; capture_en = 1'b0;
        checks++; if (state_o !== 2'd0 || fill_level !== 5'd0 || overflow !== 1'b0 || drop_count !== '0) begin
            errors++; $display("FAIL ign_clear got st=%0d fill=%0d ovf=%b drop=%0d exp 0/0/0/0", state_o, fill_level, overflow, drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = {4'($urandom_range(1, 15)), 30'($urandom)};
            tick();
            checks++; if (fill_level !== 5'd0 || state_o !== 2'd0) begin
                errors++; $display("FAIL ign_idle_push got fill=%0d st=%0d exp 0/0", fill_level, state_o);
            end
        end
        dct_valid = 1'b0;
    endtask

    task automatic test_drain();
        int pops, last_pop_cyc, ended_cyc;
        capture_en = 1'b1; rd_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = {4'($urandom_range(1, 15)), 30'($urandom)};
            tick();
        end
        dct_valid = 1'b0; test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        checks++; if (state_o !== 2'd2 || fill_level !== 5'd5) begin
            errors++; $display("FAIL drain_enter got st=%0d fill=%0d exp 2/5", state_o, fill_level);
        end
        pops = 0; last_pop_cyc = -1; ended_cyc = -1;
        for (int i = 0; i < 30 && ended_cyc < 0; i++) begin
            rd_ready = i[0];
            if (m_q.size() != 0 && rd_ready) begin
                pops++;
                checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL drain_data%0d got %h exp %h", pops, rd_data, m_q[0]); end
            end
            tick();
            if (pops == 5 && last_pop_cyc < 0) last_pop_cyc = cyc;
            if (test_has_ended === 1'b1) ended_cyc = cyc;
        end
        rd_ready = 1'b0;
        checks++; if (ended_cyc < 0 || ended_cyc != last_pop_cyc + 1) begin
            errors++; $display("FAIL drain_ended_timing got cyc=%0d exp %0d", ended_cyc, last_pop_cyc + 1);
        end
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL drain_ended_state got %0d exp 3", state_o); end
        tick();
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL drain_ended_hold got %0d exp 3", state_o); end
        clear = 1'b1; capture_en = 1'b0;
        tick();
        clear = 1'b0;
        checks++; if (state_o !== 2'd0 || fill_level !== 5'd0 || drop_count !== '0 || test_has_ended !== 1'b0) begin
            errors++; $display("FAIL drain_clear got st=%0d fill=%0d drop=%0d ended=%b exp 0/0/0/0", state_o, fill_level, drop_count, test_has_ended);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] exp_data;
        for (int i = 0; i < 400; i++) begin
            clear       = ($urandom_range(0, 60) == 0);
            capture_en  = ($urandom_range(0, 3) != 0);
            test_ending = ($urandom_range(0, 40) == 0);
            dct_valid   = $urandom_range(0, 1) == 1;
            dct_count   = 4'($urandom_range(0, 15));
            dct_buffer  = 30'($urandom);
            rd_ready    = ($urandom_range(0, 2) == 0);
            tick();
            exp_data = (m_q.size() != 0) ? m_q[0] : '0;
            checks++; if (state_o !== m_state) begin errors++; $display("FAIL rnd_state@%0d got %0d exp %0d", i, state_o, m_state); end
            checks++; if (fill_level !== 5'(m_q.size())) begin errors++; $display("FAIL rnd_fill@%0d got %0d exp %0d", i, fill_level, m_q.size()); end
            checks++; if (rd_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d got %b", i, rd_valid); end
            checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL rnd_data@%0d got %h exp %h", i, rd_data, exp_data); end
            checks++; if (overflow !== m_ovf || drop_count !== m_drop) begin
                errors++; $display("FAIL rnd_drop@%0d got ovf=%b drop=%0d exp %b/%0d", i, overflow, drop_count, m_ovf, m_drop);
            end
            checks++; if (test_has_ended !== (m_state == 2'd3)) begin errors++; $display("FAIL rnd_ended@%0d got %b", i, test_has_ended); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0; capture_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            dct_valid = 1'b1;
            {dct_count, dct_buffer} = {4'($urandom_range(1, 15)), 30'($urandom)};
            tick();
        end
        dct_valid = 1'b0; test_ending = 1'b1;
        tick();
        test_ending = 1'b0; rd_ready = 1'b1;
        tick();
        checks++; if (state_o !== 2'd2 || fill_level !== 5'd3) begin
            errors++; $display("FAIL arst_pre got st=%0d fill=%0d exp 2/3", state_o, fill_level);
        end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (state_o !== 2'd0 || fill_level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== '0 || test_has_ended !== 1'b0) begin
            errors++; $display("FAIL arst_async got st=%0d fill=%0d v=%b data=%h ended=%b exp all 0", state_o, fill_level, rd_valid, rd_data, test_has_ended);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

`ifdef NIOS2_OCI_TRACE_MON_TIMESTAMP_EN
    task automatic test_timestamp();
        capture_en = 1'b1; rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        dct_valid = 1'b1; dct_count = 4'd1; dct_buffer = 30'h111;
        tick();
        dct_valid = 1'b0;
        tick(); tick();
        dct_valid = 1'b1; dct_count = 4'd2; dct_buffer = 30'h222;
        tick();
        dct_valid = 1'b0;
        checks++; if (rd_data[15:0] !== 16'd10) begin errors++; $display("FAIL ts_first got %0d exp 10", rd_data[15:0]); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++; if (rd_data[15:0] !== 16'd13) begin errors++; $display("FAIL ts_second got %0d exp 13", rd_data[15:0]); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_ignored();
        test_drain();
        test_random();
        test_async_reset();
`ifdef NIOS2_OCI_TRACE_MON_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
